right_shift_unit: RTL

Sequential right-shift engine for the DSP datapath: the complement of the existing single-cycle left shifter. It accepts an operand and a shift amount on a start strobe and shifts right by one bit per clock, logical or arithmetic. It returns the result, the last bit shifted out and a one-cycle done pulse. It serves the ALU's divide-by-2^N and scaling operations, where one bit per cycle meets area targets better than a barrel shifter.

---
 rtl/dsp_shift_pkg.sv | 20 ++
 rtl/right_shift_unit_if.sv | 54 +++++
 rtl/right_shift_unit_rshift_step.sv | 27 ++
 rtl/right_shift_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dsp_shift_pkg.sv
// -----------------------------------------------------------------------------
// dsp_shift_pkg
// Shared definitions for the DSP shift datapath.
//   - rshift_state_e : FSM state encoding of the sequential right shifter
//   - DEF_WIDTH      : default operand/result width (shared with the left shifter users)
//   - DEF_SHAMT_W    : default shift-amount width
// -----------------------------------------------------------------------------
package dsp_shift_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SHAMT_W = 3;

  // Explicit encodings keep the state values stable for legacy tooling.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rshift_state_e;

endpackage

// File: rtl/right_shift_unit_if.sv
// -----------------------------------------------------------------------------
// right_shift_unit_if
// Request/response bundle of the sequential right shifter.
//   Start  : request strobe (master -> slave)
//   In1    : operand, WIDTH bits
//   Amount : shift count, SHAMT_W bits
//   Arith  : 1 = sign fill, 0 = zero fill
//   Out    : result, WIDTH bits (slave -> master)
//   Carry  : last bit shifted out
//   Busy   : operation in progress
//   Done   : one-cycle completion pulse
//   Sticky : OR of all shifted-out bits (only when RSHIFT_STICKY_EN is defined)
// Modports: master (requester), slave (right_shift_unit).
// -----------------------------------------------------------------------------
interface right_shift_unit_if
  import dsp_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
);

  logic               Start;
  logic [WIDTH-1:0]   In1;
  logic [SHAMT_W-1:0] Amount;
  logic               Arith;
  logic [WIDTH-1:0]   Out;
  logic               Carry;
  logic               Busy;
  logic               Done;
`ifdef RSHIFT_STICKY_EN
  logic               Sticky;

  modport master (
    output Start, In1, Amount, Arith,
    input  Out, Carry, Busy, Done, Sticky
  );

  modport slave (
    input  Start, In1, Amount, Arith,
    output Out, Carry, Busy, Done, Sticky
  );
`else
  modport master (
    output Start, In1, Amount, Arith,
    input  Out, Carry, Busy, Done
  );

  modport slave (
    input  Start, In1, Amount, Arith,
    output Out, Carry, Busy, Done
  );
`endif

endinterface

// File: rtl/right_shift_unit_rshift_step.sv
// -----------------------------------------------------------------------------
// rshift_step
// Combinational one-bit right-shift stage.
//   work      in  WIDTH : current value
//   arith     in  1     : 1 = replicate MSB, 0 = shift in zero
//   next_work out WIDTH : value shifted right by one
//   bit_out   out 1     : bit leaving at the LSB
// -----------------------------------------------------------------------------
module rshift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] work,
  input  logic             arith,
  output logic [WIDTH-1:0] next_work,
  output logic             bit_out
);

  logic fill_s;

  // One-position shift with sign or zero fill.
  always_comb begin
    fill_s    = arith & work[WIDTH-1];
    next_work = {fill_s, work[WIDTH-1:1]};
    bit_out   = work[0];
  end

endmodule

// File: rtl/right_shift_unit.sv
// -----------------------------------------------------------------------------
// right_shift_unit
// Sequential right shifter, one bit per clock, logical or arithmetic.
// Ports:
//   clk   in  : rising-edge clock
//   rst_n in  : asynchronous active-low reset
//   bus   slave modport of right_shift_unit_if
//         (Start/In1/Amount/Arith in; Out/Carry/Busy/Done[/Sticky] out)
// Optional feature macro: RSHIFT_STICKY_EN adds the Sticky output, the OR of
// every bit shifted out during the operation.
// Latency: request accepted at edge k, Done high after edge k+Amount.
// -----------------------------------------------------------------------------
module right_shift_unit
  import dsp_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input logic               clk,
  input logic               rst_n,
  right_shift_unit_if.slave bus
);

  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);

  rshift_state_e      state_r;
  logic [WIDTH-1:0]   work_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic               arith_r;
  logic [WIDTH-1:0]   out_r;
  logic               carry_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   next_work_s;
  logic               bit_out_s;
`ifdef RSHIFT_STICKY_EN
  logic               sticky_acc_r;
  logic               sticky_r;
`endif

  rshift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .work      (work_r),
    .arith     (arith_r),
    .next_work (next_work_s),
    .bit_out   (bit_out_s)
  );

  // FSM, work register, counter and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      work_r       <= '0;
      cnt_r        <= '0;
      arith_r      <= 1'b0;
      out_r        <= '0;
      carry_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef RSHIFT_STICKY_EN
      sticky_acc_r <= 1'b0;
      sticky_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            work_r       <= bus.In1;
            cnt_r        <= bus.Amount;
            arith_r      <= bus.Arith;
            busy_r       <= 1'b1;
`ifdef RSHIFT_STICKY_EN
            sticky_acc_r <= 1'b0;
`endif
            if (bus.Amount == CNT_ZERO) begin
              // Nothing to shift: publish the operand unchanged right away.
              state_r  <= DONE;
              out_r    <= bus.In1;
              carry_r  <= 1'b0;
              done_r   <= 1'b1;
`ifdef RSHIFT_STICKY_EN
              sticky_r <= 1'b0;
`endif
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        SHIFT: begin
          work_r       <= next_work_s;
          cnt_r        <= cnt_r - CNT_ONE;
`ifdef RSHIFT_STICKY_EN
          sticky_acc_r <= sticky_acc_r | bit_out_s;
`endif
          if (cnt_r == CNT_ONE) begin
            // Final shift: results are taken straight from the step output so
            // Out/Carry only ever change on entry to DONE.
            state_r  <= DONE;
            out_r    <= next_work_s;
            carry_r  <= bit_out_s;
            done_r   <= 1'b1;
`ifdef RSHIFT_STICKY_EN
            sticky_r <= sticky_acc_r | bit_out_s;
`endif
          end else begin
            state_r <= SHIFT;
          end
        end

        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Out    = out_r;
  assign bus.Carry  = carry_r;
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
`ifdef RSHIFT_STICKY_EN
  assign bus.Sticky = sticky_r;
`endif

endmodule
